// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC SPI frame serializer.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    TAIL,
    GAP
  } state_e;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Frame layout, MSB first: LEAD_ZERO_BITS zeros, PD_BITS power-down, then data.
  localparam int LEAD_ZERO_BITS = 2;
  localparam int PD_BITS        = 2;

  function automatic int pd_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int pd_msb(input int data_width);
    return data_width + PD_BITS - 1;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// rtl/dac_spi_serializer_if.sv - sample handshake and SPI pin bundle.
interface dac_spi_serializer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS*DATA_WIDTH-1:0] value_in;
  logic [1:0]                     pd_mode;
  logic                           valid_in;
  logic                           ready_out;
  logic [CHANNELS-1:0]            spi_mosi;
  logic                           spi_sck;
  logic                           spi_cs;
  logic                           frame_done;

  modport master (
    output value_in, pd_mode, valid_in,
    input  ready_out, spi_mosi, spi_sck, spi_cs, frame_done
  );

  modport slave (
    input  value_in, pd_mode, valid_in,
    output ready_out, spi_mosi, spi_sck, spi_cs, frame_done
  );
endinterface

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period clock-enable counter, 0..HALF_DIV-1.
module spi_tick_gen #(
  parameter int HALF_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (en_i && (cnt_q == LAST))) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/dac_spi_serializer.sv
// rtl/dac_spi_serializer.sv - multi-channel DAC SPI frame serializer, shared SCK/CS.
module dac_spi_serializer
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FRAME_BITS = 16,
  parameter int CHANNELS   = 2,
  parameter int HALF_DIV   = 50,
  parameter int CS_GAP     = 4
) (
  input logic                 clk_100MHz,
  input logic                 rst,
  dac_spi_serializer_if.slave bus
);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  // The IDLE cycle before the next transfer is also cs-high, so GAP itself lasts CS_GAP-1.
  localparam int GAP_CYC = (CS_GAP > 1) ? CS_GAP - 1 : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam int PD_LO = pd_lsb(DATA_WIDTH);
  localparam int PD_HI = pd_msb(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [FRAME_BITS-1:0] sh_q [CHANNELS];
  logic [FRAME_BITS-1:0] sh_d [CHANNELS];
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic [CHANNELS-1:0]   mosi_q, mosi_d;
  logic                  tick, tick_clr, tick_en, xfer;

  assign xfer     = bus.valid_in && ready_q;
  assign tick_clr = (state_d != state_q);
  assign tick_en  = state_q inside {SETUP, LOW, HIGH, TAIL};

  spi_tick_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_tick (
    .clk_i (clk_100MHz),
    .rst_i (rst),
    .clr_i (tick_clr),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SETUP;
          bit_d   = '0;
          for (int k = 0; k < CHANNELS; k++) begin
            sh_d[k]                   = '0;
            sh_d[k][DATA_WIDTH-1:0]   = bus.value_in[k*DATA_WIDTH +: DATA_WIDTH];
            sh_d[k][PD_HI:PD_LO]      = bus.pd_mode;
          end
        end
      end
      SETUP: begin
        if (tick) state_d = LOW;
      end
      LOW: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = TAIL;
          end else begin
            // Next bit appears on the same edge sck rises, giving a full half-period of setup.
            state_d = HIGH;
            bit_d   = bit_q + 1'b1;
            for (int k = 0; k < CHANNELS; k++) begin
              sh_d[k] = {sh_q[k][FRAME_BITS-2:0], 1'b0};
            end
          end
        end
      end
      HIGH: begin
        if (tick) state_d = LOW;
      end
      TAIL: begin
        if (tick) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = (CS_GAP > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered decodes of the next state, so they never follow inputs combinationally.
    cs_d    = (state_d == IDLE) || (state_d == GAP);
    sck_d   = (state_d != LOW);
    ready_d = (state_d == IDLE);
    for (int k = 0; k < CHANNELS; k++) begin
      mosi_d[k] = (state_d inside {SETUP, LOW, HIGH}) ? sh_d[k][FRAME_BITS-1] : 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        sh_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      mosi_q  <= mosi_d;
      sh_q    <= sh_d;
    end
  end

  assign bus.ready_out  = ready_q;
  assign bus.spi_cs     = cs_q;
  assign bus.spi_sck    = sck_q;
  assign bus.spi_mosi   = mosi_q;
  assign bus.frame_done = done_q;
endmodule
